enigma_ctrl: RTL and testbench

Sequencer for a chain of NUM_ROTORS rotor instances (set/en/valid/dec/din in; dout/done out).
- Loads rotor configuration.
- Accepts one ASCII character at a time over a valid/ready handshake.
- Passes the character through each rotor in turn: forward order for encode, reverse order for decode.
- Returns the result over a valid/ready handshake.
- Steps the rotors odometer-style after each letter.

Sits between the host/UART front end and the rotor array.

---
 rtl/enigma_pkg.sv | 34 +++
 rtl/enigma_ctrl_stepper.sv | 52 +++++
 rtl/enigma_ctrl.sv | 164 ++++++++++++++++
 tb/tb_enigma_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : enigma_pkg                                            |
// | Description : Shared types and constants for the rotor sequencer    |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
package enigma_pkg;

   // Controller states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CFG   = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      STEP  = 3'd4,
      OUT   = 3'd5,
      ERR   = 3'd6
   } state_t;

   localparam logic [7:0] ASCII_A = 8'd65;
   localparam logic [7:0] ASCII_Z = 8'd90;
   localparam int         ALPHA   = 26;

   localparam int OFFSET_W = 32;
   localparam int DELAY_W  = 32;
   localparam int IDX_W    = 208;

   // Only upper-case letters travel through the rotors
   function automatic logic is_upper(input logic [7:0] c);
      return (c >= ASCII_A) && (c <= ASCII_Z);
   endfunction

endpackage
`default_nettype wire

// File: rtl/enigma_ctrl_stepper.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : rotor_stepper                                         |
// | Description : Odometer-style mod-26 position counters, one per      |
// |               rotor, producing the per-rotor step strobes           |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module rotor_stepper
   import enigma_pkg::*;
#(
   parameter int NUM_ROTORS = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  step,
   output logic [NUM_ROTORS-1:0] en
);

   localparam logic [4:0] LAST_POS = 5'(ALPHA - 1);

   logic [4:0]            r_cnt [NUM_ROTORS];
   logic [NUM_ROTORS-1:0] w_carry;

   // Rotor j advances only when every lower rotor sits on its last position
   always_comb begin
      w_carry    = '0;
      w_carry[0] = 1'b1;
      for (int j = 1; j < NUM_ROTORS; j++) begin
         w_carry[j] = w_carry[j-1] & (r_cnt[j-1] == LAST_POS);
      end
   end

   assign en = step ? w_carry : '0;

   generate
      for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_cnt
         // Position counter, wraps 25 -> 0 when its strobe fires
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_cnt[g] <= '0;
            end else if (clear) begin
               r_cnt[g] <= '0;
            end else if (en[g]) begin
               r_cnt[g] <= (r_cnt[g] == LAST_POS) ? 5'd0 : r_cnt[g] + 5'd1;
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/enigma_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : enigma_ctrl                                           |
// | Description : Sequencer that loads rotor configuration, routes one  |
// |               character through the rotor chain and steps rotors    |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module enigma_ctrl
   import enigma_pkg::*;
#(
   parameter int NUM_ROTORS = 3,
   parameter int TIMEOUT    = 1024
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           cfg_load,
   input  logic [OFFSET_W*NUM_ROTORS-1:0] cfg_offset,
   input  logic [DELAY_W*NUM_ROTORS-1:0]  cfg_delay,
   input  logic [IDX_W*NUM_ROTORS-1:0]    cfg_idx,
   input  logic                           dec,
   input  logic                           in_valid,
   input  logic [7:0]                     in_char,
   output logic                           in_ready,
   output logic                           out_valid,
   output logic [7:0]                     out_char,
   input  logic                           out_ready,
   output logic                           busy,
   output logic                           err,
   output logic [NUM_ROTORS-1:0]          rot_set,
   output logic [NUM_ROTORS-1:0]          rot_en,
   output logic [NUM_ROTORS-1:0]          rot_valid,
   output logic [7:0]                     rot_din,
   output logic                           rot_dec,
   output logic [OFFSET_W*NUM_ROTORS-1:0] rot_offset,
   output logic [DELAY_W*NUM_ROTORS-1:0]  rot_delay,
   output logic [IDX_W*NUM_ROTORS-1:0]    rot_idx,
   input  logic [8*NUM_ROTORS-1:0]        rot_dout,
   input  logic [NUM_ROTORS-1:0]          rot_done
);

   localparam int              KW         = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
   localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [KW-1:0]   K_LAST     = KW'(NUM_ROTORS - 1);
   localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

   state_t        r_state;
   state_t        w_next;
   logic          r_up;      // low until the first clock after reset release
   logic [7:0]    r_cur;     // character currently in flight
   logic          r_dir;     // direction captured at accept
   logic [KW-1:0] r_k;       // rotor currently being served
   logic [TW-1:0] r_timer;

   logic          w_accept;
   logic          w_done_k;
   logic [7:0]    w_dout_k;
   logic          w_last;

   assign w_accept = (r_state == IDLE) && !cfg_load && in_valid && r_up;
   assign w_done_k = rot_done[r_k];
   assign w_dout_k = rot_dout[r_k*8 +: 8];
   assign w_last   = r_dir ? (r_k == '0) : (r_k == K_LAST);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_up    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_up    <= 1'b1;
      end
   end

   // Next-state decode; in_ready is only offered in IDLE with no config load pending
   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = r_up & ~cfg_load;
            if (cfg_load) begin
               w_next = CFG;
            end else if (w_accept) begin
               w_next = is_upper(in_char) ? ISSUE : OUT;
            end
         end
         CFG:   w_next = IDLE;
         ISSUE: w_next = WAIT;
         WAIT: begin
            if (w_done_k) begin
               w_next = w_last ? STEP : ISSUE;
            end else if (r_timer == TIMER_LAST) begin
               w_next = ERR;
            end
         end
         STEP:  w_next = OUT;
         OUT:   if (out_ready) w_next = IDLE;
         ERR:   w_next = ERR;
         default: w_next = IDLE;
      endcase
   end

   // Datapath: character, direction, rotor index, timeout timer and configuration
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cur      <= '0;
         r_dir      <= 1'b0;
         r_k        <= '0;
         r_timer    <= '0;
         rot_offset <= '0;
         rot_delay  <= '0;
         rot_idx    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cfg_load) begin
                  // Captured on entry to CFG so rotors see it alongside rot_set
                  rot_offset <= cfg_offset;
                  rot_delay  <= cfg_delay;
                  rot_idx    <= cfg_idx;
               end else if (w_accept) begin
                  r_cur <= in_char;
                  r_dir <= dec;
                  r_k   <= dec ? K_LAST : '0;
               end
            end
            ISSUE: r_timer <= '0;
            WAIT: begin
               if (w_done_k) begin
                  r_cur <= w_dout_k;
                  if (!w_last) begin
                     r_k <= r_dir ? r_k - 1'b1 : r_k + 1'b1;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   rotor_stepper #(
      .NUM_ROTORS (NUM_ROTORS)
   ) u_stepper (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (r_state == CFG),
      .step    (r_state == STEP),
      .en      (rot_en)
   );

   assign busy      = (r_state != IDLE);
   assign err       = (r_state == ERR);
   assign out_valid = (r_state == OUT);
   assign out_char  = r_cur;
   assign rot_set   = {NUM_ROTORS{r_state == CFG}};
   assign rot_valid = (r_state == ISSUE) ? (NUM_ROTORS'(1) << r_k) : '0;
   assign rot_din   = r_cur;
   assign rot_dec   = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_enigma_ctrl.sv
`timescale 1ns/1ps
module tb_enigma_ctrl;

   localparam int NR = 3;
   localparam int TO = 16;
   localparam int LETTER_LAT = 1 + NR * (1 + 3) + 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic              cfg_load = 1'b0;
   logic [32*NR-1:0]  cfg_offset = '0;
   logic [32*NR-1:0]  cfg_delay = '0;
   logic [208*NR-1:0] cfg_idx = '0;
   logic              dec = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_char = '0;
   logic              in_ready;
   logic              out_valid;
   logic [7:0]        out_char;
   logic              out_ready = 1'b0;
   logic              busy, err;
   logic [NR-1:0]     rot_set, rot_en, rot_valid;
   logic [7:0]        rot_din;
   logic              rot_dec;
   logic [32*NR-1:0]  rot_offset, rot_delay;
   logic [208*NR-1:0] rot_idx;
   logic [8*NR-1:0]   rot_dout;
   logic [NR-1:0]     rot_done;

   enigma_ctrl #(.NUM_ROTORS(NR), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_offset(cfg_offset),
      .cfg_delay(cfg_delay), .cfg_idx(cfg_idx), .dec(dec), .in_valid(in_valid),
      .in_char(in_char), .in_ready(in_ready), .out_valid(out_valid), .out_char(out_char),
      .out_ready(out_ready), .busy(busy), .err(err), .rot_set(rot_set), .rot_en(rot_en),
      .rot_valid(rot_valid), .rot_din(rot_din), .rot_dec(rot_dec), .rot_offset(rot_offset),
      .rot_delay(rot_delay), .rot_idx(rot_idx), .rot_dout(rot_dout), .rot_done(rot_done)
   );

   // Stub rotors: output din+1, done three cycles after valid (unless hung)
   logic [2:0]    vpipe [NR];
   logic [7:0]    sdata [NR];
   logic [NR-1:0] hang = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NR; k++) begin
            vpipe[k] <= '0;
            sdata[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NR; k++) begin
            vpipe[k] <= {vpipe[k][1:0], rot_valid[k]};
            if (rot_valid[k]) sdata[k] <= rot_din + 8'd1;
         end
      end
   end

   always_comb begin
      rot_done = '0;
      rot_dout = '0;
      for (int k = 0; k < NR; k++) begin
         rot_done[k]       = vpipe[k][2] & ~hang[k];
         rot_dout[k*8 +: 8] = sdata[k];
      end
   end

   // Strobe monitor
   int            vq[$];
   logic          dq[$];
   logic [NR-1:0] eq[$];
   int            set_cnt = 0;
   int            viol = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         for (int k = 0; k < NR; k++) if (rot_valid[k]) begin
            vq.push_back(k);
            dq.push_back(rot_dec);
         end
         if (rot_en != '0) eq.push_back(rot_en);
         if (rot_set != '0) set_cnt++;
         if (int'(rot_valid != '0) + int'(rot_en != '0) + int'(rot_set != '0) > 1) viol++;
         if (rot_valid != '0 && !$onehot(rot_valid)) viol++;
      end
   end

   int n_vec = 0;
   int n_err = 0;
   int nlet = 0;   // letters stepped since counters were last cleared

   logic [7:0] r_got;
   int         r_lat;
   bit         r_tmo, r_leak, r_unstable;

   // Reference step pattern: rotor j steps when the letter index's low j base-26 digits are all 25
   function automatic logic [NR-1:0] exp_en(input int n);
      logic [NR-1:0] e;
      int p;
      e = '0; e[0] = 1'b1; p = 1;
      for (int j = 1; j < NR; j++) begin
         p = p * 26;
         e[j] = ((n % p) == (p - 1));
      end
      return e;
   endfunction

   function automatic logic [7:0] exp_out(input logic [7:0] c);
      return (c >= 8'd65 && c <= 8'd90) ? c + 8'(NR) : c;
   endfunction

   task automatic clear_q();
      vq.delete(); dq.delete(); eq.delete();
   endtask

   task automatic do_char(input logic [7:0] c, input logic d, input int hold, input bit poke);
      int cyc;
      r_tmo = 0; r_leak = 0; r_unstable = 0; r_lat = 0; r_got = '0;
      @(negedge clk);
      in_char = c; dec = d; in_valid = 1'b1;
      cyc = 0;
      while (!in_ready) begin
         @(negedge clk);
         cyc++;
         if (cyc > 50) begin r_tmo = 1; in_valid = 1'b0; return; end
      end
      @(negedge clk);
      in_valid = 1'b0; dec = ~d; in_char = 8'($urandom);
      r_lat = 1;
      while (!out_valid) begin
         if (in_ready) r_leak = 1;
         @(negedge clk);
         r_lat++;
         if (r_lat > 200) begin r_tmo = 1; return; end
      end
      r_got = out_char;
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            cfg_load = (i == 2);
            in_valid = (i == 4);
            in_char  = 8'($urandom_range(65, 90));
         end
         @(negedge clk);
         if (!out_valid || out_char !== r_got || in_ready) r_unstable = 1;
      end
      cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
          rot_set !== '0 || rot_en !== '0 || rot_valid !== '0 || rot_offset !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b err=%b set=%b en=%b valid=%b, required all 0",
                  in_ready, out_valid, busy, err, rot_set, rot_en, rot_valid);
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: in_ready=%b busy=%b, required 1/0", in_ready, busy);
      end
      nlet = 0;
   endtask

   task automatic test_encode();
      bit ok;
      clear_q();
      do_char(8'd65, 1'b0, 0, 0);
      n_vec++;
      if (r_tmo || r_got !== 8'd68 || r_lat != LETTER_LAT) begin
         n_err++;
         $display("FAIL encode_out: got=%h lat=%0d tmo=%0d, required 44 lat=%0d", r_got, r_lat, r_tmo, LETTER_LAT);
      end
      ok = (vq.size() == NR);
      for (int i = 0; i < NR && ok; i++) ok = (vq[i] == i) && (dq[i] == 1'b0);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL encode_order: %0d issues seen, required 0..%0d ascending", vq.size(), NR-1); end
      n_vec++;
      if (eq.size() != 1 || eq[0] !== 3'b001) begin
         n_err++;
         $display("FAIL encode_step: pulses=%0d first=%b, required 1 x 001", eq.size(), (eq.size() > 0) ? eq[0] : 3'b000);
      end
      n_vec++;
      if (r_leak || viol != 0) begin n_err++; $display("FAIL encode_ready: leak=%0d viol=%0d, required 0/0", r_leak, viol); end
      nlet++;
   endtask

   task automatic test_decode();
      bit ok;
      clear_q();
      do_char(8'd65, 1'b1, 0, 0);
      n_vec++;
      if (r_tmo || r_got !== 8'd68 || r_lat != LETTER_LAT) begin
         n_err++;
         $display("FAIL decode_out: got=%h lat=%0d tmo=%0d, required 44 lat=%0d", r_got, r_lat, r_tmo, LETTER_LAT);
      end
      ok = (vq.size() == NR);
      for (int i = 0; i < NR && ok; i++) ok = (vq[i] == NR - 1 - i) && (dq[i] == 1'b1);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL decode_order: %0d issues seen, required %0d..0 with dec=1", vq.size(), NR-1); end
      n_vec++;
      if (eq.size() != 1 || eq[0] !== exp_en(nlet)) begin
         n_err++;
         $display("FAIL decode_step: pulses=%0d, required 1 x %b", eq.size(), exp_en(nlet));
      end
      nlet++;
   endtask

   task automatic test_nonletter();
      clear_q();
      do_char(8'h35, 1'b0, 0, 0);
      n_vec++;
      if (r_tmo || r_got !== 8'h35 || r_lat != 1) begin
         n_err++;
         $display("FAIL nonletter_out: got=%h lat=%0d, required 35 lat=1", r_got, r_lat);
      end
      n_vec++;
      if (vq.size() != 0 || eq.size() != 0) begin
         n_err++;
         $display("FAIL nonletter_strobes: issues=%0d steps=%0d, required 0/0", vq.size(), eq.size());
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] c;
      int s0;
      c = 8'($urandom_range(65, 90));
      s0 = set_cnt;
      clear_q();
      do_char(c, 1'b0, 10, 1);
      n_vec++;
      if (r_tmo || r_got !== exp_out(c) || r_unstable) begin
         n_err++;
         $display("FAIL hold_out: got=%h unstable=%0d, required %h stable", r_got, r_unstable, exp_out(c));
      end
      n_vec++;
      if (set_cnt != s0 || vq.size() != NR || busy !== 1'b0) begin
         n_err++;
         $display("FAIL hold_ignore: sets=%0d issues=%0d busy=%b, required 0/%0d/0", set_cnt - s0, vq.size(), busy, NR);
      end
      nlet++;
   endtask

   task automatic test_cfg_priority();
      int s0;
      s0 = set_cnt;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         cfg_offset[32*i +: 32] = $urandom;
         cfg_delay[32*i +: 32]  = $urandom;
      end
      for (int i = 0; i < 26 * NR; i++) cfg_idx[8*i +: 8] = 8'($urandom);
      cfg_load = 1'b1; in_valid = 1'b1; in_char = 8'd66;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL cfg_ready: in_ready=%b, required 0", in_ready); end
      @(negedge clk);
      cfg_load = 1'b0; in_valid = 1'b0;
      n_vec++;
      if (rot_set !== '1 || rot_offset !== cfg_offset || rot_delay !== cfg_delay || rot_idx !== cfg_idx) begin
         n_err++;
         $display("FAIL cfg_set: set=%b offset=%h, required 111 %h", rot_set, rot_offset, cfg_offset);
      end
      @(negedge clk);
      n_vec++;
      if (set_cnt != s0 + 1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL cfg_once: sets=%0d busy=%b, required 1/0", set_cnt - s0, busy);
      end
      nlet = 0;
      clear_q();
      do_char(8'd66, 1'b0, 0, 0);
      n_vec++;
      if (r_got !== 8'd69 || eq.size() != 1 || eq[0] !== 3'b001) begin
         n_err++;
         $display("FAIL cfg_first: got=%h steps=%0d, required 45 and 1 x 001", r_got, eq.size());
      end
      nlet++;
   endtask

   task automatic test_stepping();
      logic [7:0] c;
      logic d;
      bit ok, letter;
      int c1, c2, guard;
      c1 = 0; c2 = 0; guard = 0;
      while (nlet < 677 && guard < 1000) begin
         guard++;
         if ($urandom_range(0, 7) == 0)
            c = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 64)) : 8'($urandom_range(91, 255));
         else
            c = 8'($urandom_range(65, 90));
         d = 1'($urandom_range(0, 1));
         letter = (c >= 8'd65 && c <= 8'd90);
         clear_q();
         do_char(c, d, $urandom_range(0, 2), 0);
         n_vec++;
         if (r_tmo || r_got !== exp_out(c)) begin
            n_err++;
            $display("FAIL step_out: char=%h dec=%b got=%h, required %h", c, d, r_got, exp_out(c));
         end
         if (letter) begin
            ok = (vq.size() == NR);
            for (int i = 0; i < NR && ok; i++) ok = (vq[i] == (d ? NR - 1 - i : i));
            n_vec++;
            if (!ok) begin n_err++; $display("FAIL step_order: char=%h dec=%b issues=%0d, required %0d in order", c, d, vq.size(), NR); end
            n_vec++;
            if (eq.size() != 1 || eq[0] !== exp_en(nlet)) begin
               n_err++;
               $display("FAIL step_en: letter %0d pulses=%0d en=%b, required %b", nlet, eq.size(), (eq.size() > 0) ? eq[0] : 3'b000, exp_en(nlet));
            end
            if (nlet < 676 && eq.size() == 1) begin
               if (eq[0][1]) c1++;
               if (eq[0][2]) c2++;
            end
            nlet++;
         end else begin
            n_vec++;
            if (vq.size() != 0 || eq.size() != 0) begin
               n_err++;
               $display("FAIL step_nonletter: char=%h issues=%0d steps=%0d, required 0/0", c, vq.size(), eq.size());
            end
         end
      end
      n_vec++;
      if (c1 != 26 || c2 != 1 || nlet != 677) begin
         n_err++;
         $display("FAIL step_counts: en1=%0d en2=%0d letters=%0d, required 26/1/677", c1, c2, nlet);
      end
      n_vec++;
      if (viol != 0) begin n_err++; $display("FAIL strobe_exclusive: violations=%0d, required 0", viol); end
   endtask

   task automatic test_timeout();
      int cyc;
      hang = 3'b010;
      clear_q();
      @(negedge clk);
      in_char = 8'd65; dec = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!rot_valid[1] && cyc < 40) begin @(negedge clk); cyc++; end
      n_vec++;
      if (!rot_valid[1]) begin n_err++; $display("FAIL timeout_issue: rotor1 valid=%b, required 1", rot_valid[1]); end
      in_valid = 1'b1;
      for (int i = 1; i <= TO; i++) @(negedge clk);
      n_vec++;
      if (err !== 1'b0) begin n_err++; $display("FAIL timeout_early: err=%b at %0d cycles, required 0", err, TO); end
      @(negedge clk);
      n_vec++;
      if (err !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_err: err=%b busy=%b in_ready=%b, required 1/1/0", err, busy, in_ready);
      end
      repeat (5) @(negedge clk);
      n_vec++;
      if (err !== 1'b1 || in_ready !== 1'b0 || rot_valid !== '0 || rot_en !== '0 || rot_set !== '0) begin
         n_err++;
         $display("FAIL timeout_sticky: err=%b in_ready=%b strobes=%b%b%b, required 1/0/000", err, in_ready, rot_valid, rot_en, rot_set);
      end
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      n_vec++;
      if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: err=%b busy=%b out_valid=%b in_ready=%b, required 0/0/0/0", err, busy, out_valid, in_ready);
      end
      hang = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      nlet = 0;
      clear_q();
      do_char(8'd65, 1'b0, 0, 0);
      n_vec++;
      if (r_tmo || r_got !== 8'd68 || eq.size() != 1 || eq[0] !== 3'b001) begin
         n_err++;
         $display("FAIL after_reset: got=%h steps=%0d, required 44 and 1 x 001", r_got, eq.size());
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_encode();
      test_decode();
      test_nonletter();
      test_backpressure();
      test_cfg_priority();
      test_stepping();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
